// File: rtl/swankmania_hdl.sv
// Bring-up top: button-started SRAM write/read-back test plus GPIO0 loopback counter test.
// Latency: 2 cycles per SRAM word per phase; optional loopback (COM_TEST_EN) steps every ComDiv cycles.
module swankmania_hdl #(
  parameter int AddrWidth = 18,
  parameter int ComDiv    = 50_000
) (
  input  logic        iClk50,
  input  logic        iReset,
  input  logic [17:0] iSwitch,
  input  logic [3:0]  iButton_,
  output logic [17:0] oLEDR,
  output logic [8:0]  oLEDG,
  output logic [6:0]  oHex7,
  output logic [6:0]  oHex6,
  output logic [6:0]  oHex5,
  output logic [6:0]  oHex4,
  output logic [6:0]  oHex3,
  output logic [6:0]  oHex2,
  output logic [6:0]  oHex1,
  output logic [6:0]  oHex0,
  inout  wire  [35:0] ioGPIO0,
  inout  wire  [35:0] ioGPIO1,
  output logic [17:0] oSRAM_A,
  inout  wire  [15:0] ioSRAM_IO,
  output logic        oSRAM_CE_,
  output logic        oSRAM_WE_,
  output logic        oSRAM_OE_,
  output logic        oSRAM_LB_,
  output logic        oSRAM_UB_
);

  typedef enum logic [2:0] {S_IDLE, S_WR_SET, S_WR_END, S_RD_SET, S_RD_CHK, S_PASS, S_FAIL} state_t;

  state_t                 state_q, state_d;
  logic [AddrWidth-1:0]   addr_q, addr_d, addr_nxt;
  logic [15:0]            seed_q, seed_d, io_dat_q, io_dat_d;
  logic [17:0]            fail_addr_q, fail_addr_d, a_q, a_d, disp_addr;
  logic                   ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d, io_oe_q, io_oe_d;
  logic [2:0]             btn_q, btn_d;
  logic                   start, last;
  logic [7:0]             err_cnt;
  logic                   unused_ok;

  function automatic logic [15:0] pattern(input logic [17:0] a, input logic [15:0] s);
    return a[15:0] ^ {a[17:16], 14'b0} ^ s;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // btn_q: [0],[1] synchroniser, [2] previous synchronised level for edge detect
  assign start    = btn_q[2] & ~btn_q[1];
  assign last     = &addr_q;
  assign addr_nxt = addr_q + AddrWidth'(1);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    seed_d      = seed_q;
    fail_addr_d = fail_addr_q;
    a_d         = a_q;
    ce_n_d      = ce_n_q;
    we_n_d      = we_n_q;
    oe_n_d      = oe_n_q;
    io_oe_d     = io_oe_q;
    io_dat_d    = io_dat_q;
    btn_d       = {btn_q[1:0], iButton_[0]};
    case (state_q)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          state_d     = S_WR_SET;
          seed_d      = iSwitch[15:0];
          addr_d      = '0;
          fail_addr_d = '0;
          a_d         = '0;
          ce_n_d      = 1'b0;
          we_n_d      = 1'b0;
          oe_n_d      = 1'b1;
          io_oe_d     = 1'b1;
          io_dat_d    = pattern(18'd0, iSwitch[15:0]);
        end
      end
      S_WR_SET: begin
        state_d = S_WR_END;
        we_n_d  = 1'b1;
      end
      S_WR_END: begin
        if (last) begin
          state_d = S_RD_SET;
          addr_d  = '0;
          a_d     = '0;
          io_oe_d = 1'b0;
          oe_n_d  = 1'b0;
        end else begin
          state_d  = S_WR_SET;
          addr_d   = addr_nxt;
          a_d      = 18'(addr_nxt);
          io_dat_d = pattern(18'(addr_nxt), seed_q);
          we_n_d   = 1'b0;
        end
      end
      S_RD_SET: state_d = S_RD_CHK;
      S_RD_CHK: begin
        if (ioSRAM_IO != pattern(18'(addr_q), seed_q)) begin
          state_d     = S_FAIL;
          fail_addr_d = 18'(addr_q);
          oe_n_d      = 1'b1;
          ce_n_d      = 1'b1;
        end else if (last) begin
          state_d = S_PASS;
          oe_n_d  = 1'b1;
          ce_n_d  = 1'b1;
        end else begin
          state_d = S_RD_SET;
          addr_d  = addr_nxt;
          a_d     = 18'(addr_nxt);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk50 or posedge iReset) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      seed_q      <= '0;
      fail_addr_q <= '0;
      a_q         <= '0;
      ce_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      io_oe_q     <= 1'b0;
      io_dat_q    <= '0;
      btn_q       <= 3'b111;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      seed_q      <= seed_d;
      fail_addr_q <= fail_addr_d;
      a_q         <= a_d;
      ce_n_q      <= ce_n_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      io_oe_q     <= io_oe_d;
      io_dat_q    <= io_dat_d;
      btn_q       <= btn_d;
    end
  end

`ifdef COM_TEST_EN
  localparam int DivW = $clog2(ComDiv + 1);
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      com_q, com_d, sen1_q, sen1_d, sen2_q, sen2_d, err_q, err_d;
  logic            armed_q, armed_d;

  always_comb begin
    div_d   = div_q + DivW'(1);
    com_d   = com_q;
    err_d   = err_q;
    armed_d = armed_q;
    sen1_d  = ioGPIO0[15:8];
    sen2_d  = sen1_q;
    if (div_q == DivW'(ComDiv - 1)) begin
      div_d   = '0;
      com_d   = com_q + 8'd1;
      armed_d = 1'b1;
      // com_q still holds the value driven before this step
      if (armed_q && (sen2_q != com_q) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end
  end

  always_ff @(posedge iClk50 or posedge iReset) begin
    if (iReset) begin
      div_q   <= '0;
      com_q   <= '0;
      sen1_q  <= '0;
      sen2_q  <= '0;
      err_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      com_q   <= com_d;
      sen1_q  <= sen1_d;
      sen2_q  <= sen2_d;
      err_q   <= err_d;
      armed_q <= armed_d;
    end
  end

  assign ioGPIO0   = {{28{1'bz}}, com_q};
  assign err_cnt   = err_q;
  assign unused_ok = &{1'b0, ioGPIO0[35:16], ioGPIO0[7:0], iButton_[3:1]};
`else
  assign ioGPIO0   = {36{1'bz}};
  assign err_cnt   = 8'd0;
  assign unused_ok = &{1'b0, iButton_[3:1]};
`endif

  assign ioGPIO1   = {36{1'bz}};
  assign ioSRAM_IO = io_oe_q ? io_dat_q : {16{1'bz}};
  assign oSRAM_A   = a_q;
  assign oSRAM_CE_ = ce_n_q;
  assign oSRAM_WE_ = we_n_q;
  assign oSRAM_OE_ = oe_n_q;
  assign oSRAM_LB_ = 1'b0;
  assign oSRAM_UB_ = 1'b0;

  assign oLEDR     = iSwitch;
  assign oLEDG     = {5'b0, err_cnt != 8'd0, state_q == S_FAIL, state_q == S_PASS,
                      state_q inside {S_WR_SET, S_WR_END, S_RD_SET, S_RD_CHK}};
  assign disp_addr = (state_q == S_FAIL) ? fail_addr_q : 18'd0;
  assign oHex7     = seg7(err_cnt[7:4]);
  assign oHex6     = seg7(err_cnt[3:0]);
  assign oHex5     = seg7(4'h0);
  assign oHex4     = seg7({2'b00, disp_addr[17:16]});
  assign oHex3     = seg7(disp_addr[15:12]);
  assign oHex2     = seg7(disp_addr[11:8]);
  assign oHex1     = seg7(disp_addr[7:4]);
  assign oHex0     = seg7(disp_addr[3:0]);

endmodule

// File: tb/tb_swankmania_hdl.sv
// Bench for swankmania_hdl: behavioural SRAM, rule-level monitor, directed + randomized runs.
module tb_swankmania_hdl;
  localparam int AW = 4;
  localparam int CD = 4;
  localparam int NW = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] sw;
  logic [3:0]  btn;
  logic [17:0] ledr, a;
  logic [8:0]  ledg;
  logic [6:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;
  wire  [35:0] gpio0, gpio1;
  wire  [15:0] sram_io;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] mem [NW];
  logic        stuck, loop_mode, busy_prev;
  logic [7:0]  loop_q;
  logic [15:0] seed_m;
  int          wr_idx, rd_cyc, busy_cyc, runs;

  always #10 clk = ~clk;

  swankmania_hdl #(.AddrWidth(AW), .ComDiv(CD)) dut (
    .iClk50(clk), .iReset(rst), .iSwitch(sw), .iButton_(btn),
    .oLEDR(ledr), .oLEDG(ledg),
    .oHex7(hex7), .oHex6(hex6), .oHex5(hex5), .oHex4(hex4),
    .oHex3(hex3), .oHex2(hex2), .oHex1(hex1), .oHex0(hex0),
    .ioGPIO0(gpio0), .ioGPIO1(gpio1),
    .oSRAM_A(a), .ioSRAM_IO(sram_io),
    .oSRAM_CE_(ce_n), .oSRAM_WE_(we_n), .oSRAM_OE_(oe_n), .oSRAM_LB_(lb_n), .oSRAM_UB_(ub_n)
  );

  // asynchronous-read SRAM; optional bit-3 stuck-at-0 at word 5
  assign sram_io = (!ce_n && !oe_n)
                 ? (mem[a[AW-1:0]] & ((stuck && a == 18'd5) ? 16'hFFF7 : 16'hFFFF))
                 : 16'hzzzz;

  assign gpio0[15:8] = loop_mode ? loop_q : 8'h00;
  always @(posedge clk) loop_q <= gpio0[7:0];

  function automatic logic [15:0] pat(input logic [17:0] ad, input logic [15:0] s);
    return ad[15:0] ^ {ad[17:16], 14'b0} ^ s;
  endfunction

  function automatic int hexval(input logic [6:0] seg);
    logic [6:0] tbl [16];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    for (int i = 0; i < 16; i++) if (tbl[i] == seg) return i;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // rule-level monitor: write sequence/data, read sequence, strobe sanity, busy bookkeeping
  always @(negedge clk) begin
    if (!rst) begin
      chk("ledr_mirror", ledr, sw);
      chk("lb_ub_low", {lb_n, ub_n}, 2'b00);
      if (ledg[0]) chk("busy_ce_low", ce_n, 1'b0);
      else         chk("idle_we_oe_high", {we_n, oe_n}, 2'b11);
      if (!we_n) begin
        chk("wr_addr", a, wr_idx);
        chk("wr_data", sram_io, pat(a, seed_m));
        mem[a[AW-1:0]] = sram_io;
        wr_idx++;
      end
      if (!oe_n) begin
        chk("rd_addr", a, rd_cyc / 2);
        rd_cyc++;
      end
      if (ledg[0]) busy_cyc++;
      if (ledg[0] && !busy_prev) runs++;
      busy_prev = ledg[0];
    end
  end

  task automatic prep(input logic [15:0] s, input logic st);
    sw     = {2'($urandom_range(0, 3)), s};
    seed_m = s;
    stuck  = st;
    for (int i = 0; i < NW; i++) mem[i] = 16'($urandom);
    wr_idx = 0; rd_cyc = 0; busy_cyc = 0; runs = 0;
  endtask

  task automatic press();
    @(negedge clk) btn[0] = 1'b0;
    repeat (4) @(negedge clk);
    btn[0] = 1'b1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!ledg[0] && n < 50) begin @(negedge clk); n++; end
    chk("start_timeout", ledg[0], 1'b1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (ledg[2:1] == 2'b00 && n < 2000) begin @(negedge clk); n++; end
    chk("done_timeout", ledg[2:1] != 2'b00, 1'b1);
  endtask

  task automatic check_pass(input string tag);
    chk({tag, "_ledg"}, ledg, 9'b000000010);
    chk({tag, "_busy_cycles"}, busy_cyc, 64);
    chk({tag, "_writes"}, wr_idx, NW);
    chk({tag, "_read_cycles"}, rd_cyc, 2 * NW);
    chk({tag, "_hex4_0"}, {hex4, hex3, hex2, hex1, hex0}, {5{7'h40}});
  endtask

  initial begin
    int n, c;
    rst = 1'b1; btn = 4'hF; sw = '0; stuck = 1'b0; loop_mode = 1'b1;
    seed_m = '0; busy_prev = 1'b0;
    prep(16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_a", a, 18'd0);
    chk("rst_ce_we_oe", {ce_n, we_n, oe_n}, 3'b111);
    chk("rst_lb_ub", {lb_n, ub_n}, 2'b00);
    chk("rst_ledg", ledg, 9'd0);
    chk("rst_hex", {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}, {8{7'h40}});
    rst = 1'b0;
    repeat (4) @(negedge clk);

    prep(16'hA5A5, 1'b0);
    press(); wait_busy(); wait_done();
    check_pass("a5a5");

    for (int r = 0; r < 3; r++) begin
      prep(16'($urandom), 1'b0);
      press(); wait_busy(); wait_done();
      check_pass("rand");
    end

    prep(16'h0008, 1'b1);
    press(); wait_busy(); wait_done();
    chk("fail_ledg", ledg, 9'b000000100);
    chk("fail_hex0", hex0, 7'h12);
    chk("fail_hex4_1", {hex4, hex3, hex2, hex1}, {4{7'h40}});
    chk("fail_read_cycles", rd_cyc, 12);
    chk("fail_busy_cycles", busy_cyc, 44);

    prep(16'h1234, 1'b0);
    @(negedge clk) btn[0] = 1'b0;
    repeat (1000) @(negedge clk);
    chk("held_runs", runs, 1);
    chk("held_ledg", ledg, 9'b000000010);
    chk("held_clears_hex0", hex0, 7'h40);
    btn[0] = 1'b1;
    repeat (5) @(negedge clk);

    prep(16'h5A5A, 1'b0);
    press(); wait_busy();
    n = 0;
    while (!(ledg[0] && we_n && oe_n) && n < 100) begin @(negedge clk); n++; end
    chk("wr_end_seen", ledg[0] && we_n && oe_n, 1'b1);
    btn[0] = 1'b0;
    repeat (3) @(negedge clk);
    btn[0] = 1'b1;
    wait_done();
    chk("restart_runs", runs, 1);
    check_pass("restart");

    prep(16'h0F0F, 1'b0);
    press(); wait_busy();
    n = 0;
    while (!(!oe_n && a == 18'd7) && n < 200) begin @(negedge clk); n++; end
    chk("rd7_seen", !oe_n && a == 18'd7, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("midrst_ce_we_oe", {ce_n, we_n, oe_n}, 3'b111);
    chk("midrst_a", a, 18'd0);
    chk("midrst_ledg", ledg, 9'd0);
    chk("midrst_hex", {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0}, {8{7'h40}});
    @(negedge clk) rst = 1'b0;
    busy_prev = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_resume", {ledg[0], ce_n}, 2'b01);

`ifdef COM_TEST_EN
    repeat (400) @(negedge clk);
    chk("loop_hex76", {hex7, hex6}, {2{7'h40}});
    chk("loop_led3", ledg[3], 1'b0);
    loop_mode = 1'b0;
    repeat (60) @(negedge clk);
    c = hexval(hex7) * 16 + hexval(hex6);
    chk("open_count_rising", (c >= 10 && c <= 15), 1'b1);
    repeat (1500) @(negedge clk);
    chk("sat_hex76", {hex7, hex6}, {2{7'h0E}});
    chk("sat_led3", ledg[3], 1'b1);
`else
    loop_mode = 1'b0;
    repeat (400) @(negedge clk);
    chk("nocom_hex76", {hex7, hex6}, {2{7'h40}});
    chk("nocom_led3", ledg[3], 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
